// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the trap sequencer: privilege encodings,
// mstatus bit positions, interrupt priority order and the CSR input bundle.
package trap_ctrl_pkg;

    localparam int CSR_XLEN = 64;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam int MS_SIE    = 1;
    localparam int MS_MIE    = 3;
    localparam int MS_SPIE   = 5;
    localparam int MS_MPIE   = 7;
    localparam int MS_SPP    = 8;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;

    localparam logic [5:0] IRQ_SSI = 6'd1;
    localparam logic [5:0] IRQ_MSI = 6'd3;
    localparam logic [5:0] IRQ_STI = 6'd5;
    localparam logic [5:0] IRQ_MTI = 6'd7;
    localparam logic [5:0] IRQ_SEI = 6'd9;
    localparam logic [5:0] IRQ_MEI = 6'd11;
    localparam int         NUM_IRQ = 6;

    localparam logic [5:0] ILLEGAL_INST = 6'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    typedef struct packed {
        logic [CSR_XLEN-1:0] mstatus;
        logic [CSR_XLEN-1:0] mie;
        logic [CSR_XLEN-1:0] mip;
        logic [CSR_XLEN-1:0] mtvec;
        logic [CSR_XLEN-1:0] stvec;
        logic [CSR_XLEN-1:0] mepc;
        logic [CSR_XLEN-1:0] sepc;
        logic [CSR_XLEN-1:0] medeleg;
        logic [CSR_XLEN-1:0] mideleg;
    } CSRPack;

    // Index 0 is the highest-priority interrupt.
    function automatic logic [5:0] irq_prio(input int idx);
        case (idx)
            0:       return IRQ_MEI;
            1:       return IRQ_MSI;
            2:       return IRQ_MTI;
            3:       return IRQ_SEI;
            4:       return IRQ_SSI;
            default: return IRQ_STI;
        endcase
    endfunction

endpackage

// File: rtl/trap_decide.sv
// Combinational event selection: picks interrupt/exception/xret for the
// committing instruction, its target bank, cause/tval and the new fetch pc.
module trap_decide
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      priv_i,
    input  CSRPack          csr_i,
    input  logic            cmt_valid_i,
    input  logic            cmt_exc_i,
    input  logic [XLEN-1:0] cmt_cause_i,
    input  logic [XLEN-1:0] cmt_tval_i,
    input  logic            cmt_mret_i,
    input  logic            cmt_sret_i,
    output logic            trap_o,
    output logic            mret_o,
    output logic            sret_o,
    output logic            to_s_o,
    output logic [XLEN-1:0] cause_o,
    output logic [XLEN-1:0] tval_o,
    output logic [XLEN-1:0] tgt_pc_o
);

    logic [XLEN-1:0] pend, exc_cause, tvec, base;
    logic            irq_hit, irq_to_s, irq_en, tgt_s, ill_xret, is_exc;
    logic [5:0]      irq_code, code;

    assign pend = csr_i.mip & csr_i.mie;

    // Lowest priority scanned first so the highest enabled bit is written last.
    always_comb begin
        irq_hit  = 1'b0;
        irq_to_s = 1'b0;
        irq_code = '0;
        code     = '0;
        irq_en   = 1'b0;
        tgt_s    = 1'b0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            code = irq_prio(k);
            if (csr_i.mideleg[code]) begin
                tgt_s  = (priv_i <= PRIV_S);
                irq_en = tgt_s ? (priv_i == PRIV_U || csr_i.mstatus[MS_SIE])
                               : (priv_i != PRIV_M);
            end else begin
                tgt_s  = 1'b0;
                irq_en = (priv_i != PRIV_M) || csr_i.mstatus[MS_MIE];
            end
            if (pend[code] && irq_en) begin
                irq_hit  = 1'b1;
                irq_to_s = tgt_s;
                irq_code = code;
            end
        end
    end

    assign ill_xret  = (cmt_mret_i && priv_i != PRIV_M) ||
                       (cmt_sret_i && priv_i == PRIV_U);
    assign is_exc    = cmt_exc_i || ill_xret;
    assign exc_cause = cmt_exc_i ? cmt_cause_i : XLEN'(ILLEGAL_INST);

    assign trap_o = cmt_valid_i && (irq_hit || is_exc);
    assign mret_o = cmt_valid_i && !irq_hit && !is_exc && cmt_mret_i;
    assign sret_o = cmt_valid_i && !irq_hit && !is_exc && !cmt_mret_i && cmt_sret_i;

    assign to_s_o = irq_hit ? irq_to_s
                            : (csr_i.medeleg[exc_cause[5:0]] && priv_i <= PRIV_S);

    always_comb begin
        cause_o = exc_cause;
        if (irq_hit) begin
            cause_o         = '0;
            cause_o[XLEN-1] = 1'b1;
            cause_o[5:0]    = irq_code;
        end
    end

    assign tval_o = (irq_hit || !cmt_exc_i) ? '0 : cmt_tval_i;

    assign tvec = to_s_o ? csr_i.stvec : csr_i.mtvec;
    assign base = {tvec[XLEN-1:2], 2'b00};

    always_comb begin
        if (mret_o)
            tgt_pc_o = csr_i.mepc;
        else if (sret_o)
            tgt_pc_o = csr_i.sepc;
        else if (irq_hit && tvec[1:0] == 2'b01)
            tgt_pc_o = base + XLEN'({irq_code, 2'b00});
        else
            tgt_pc_o = base;
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: commits an event into CSR write strobes and privilege,
// then runs a flush -> redirect sequence toward the front end.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int         XLEN         = 64,
    parameter int         FLUSH_CYCLES = 2,
    parameter logic [1:0] RESET_PRIV   = 2'd3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmt_valid,
    output logic            cmt_ready,
    input  logic [XLEN-1:0] cmt_pc,
    input  logic            cmt_exc,
    input  logic [XLEN-1:0] cmt_cause,
    input  logic [XLEN-1:0] cmt_tval,
    input  logic            cmt_mret,
    input  logic            cmt_sret,
    input  CSRPack          csr_in,
    output logic            trap_we,
    output logic            trap_to_s,
    output logic [XLEN-1:0] trap_epc,
    output logic [XLEN-1:0] trap_cause,
    output logic [XLEN-1:0] trap_tval,
    output logic            xret_we,
    output logic [XLEN-1:0] new_mstatus,
    output logic [1:0]      priv,
    output logic            switch_mode,
    output logic [XLEN-1:0] cosim_epc,
    output logic [XLEN-1:0] cosim_cause,
    output logic [XLEN-1:0] cosim_tval,
    output logic            flush,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      priv_q, priv_d, priv_new;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic [XLEN-1:0] cosim_epc_q, cosim_cause_q, cosim_tval_q;
    logic            d_trap, d_mret, d_sret, d_to_s, any_evt, evt;
    logic [XLEN-1:0] d_cause, d_tval, d_tgt_pc, mstatus_new;

    trap_decide #(.XLEN(XLEN)) u_decide (
        .priv_i      (priv_q),
        .csr_i       (csr_in),
        .cmt_valid_i (cmt_valid),
        .cmt_exc_i   (cmt_exc),
        .cmt_cause_i (cmt_cause),
        .cmt_tval_i  (cmt_tval),
        .cmt_mret_i  (cmt_mret),
        .cmt_sret_i  (cmt_sret),
        .trap_o      (d_trap),
        .mret_o      (d_mret),
        .sret_o      (d_sret),
        .to_s_o      (d_to_s),
        .cause_o     (d_cause),
        .tval_o      (d_tval),
        .tgt_pc_o    (d_tgt_pc)
    );

    assign any_evt = d_trap || d_mret || d_sret;
    assign evt     = (state_q == ST_IDLE) && any_evt;

    always_comb begin
        mstatus_new = csr_in.mstatus;
        priv_new    = priv_q;
        if (d_trap && !d_to_s) begin
            mstatus_new[MS_MPIE]             = csr_in.mstatus[MS_MIE];
            mstatus_new[MS_MIE]              = 1'b0;
            mstatus_new[MS_MPP_HI:MS_MPP_LO] = priv_q;
            priv_new                         = PRIV_M;
        end else if (d_trap) begin
            mstatus_new[MS_SPIE] = csr_in.mstatus[MS_SIE];
            mstatus_new[MS_SIE]  = 1'b0;
            mstatus_new[MS_SPP]  = priv_q[0];
            priv_new             = PRIV_S;
        end else if (d_mret) begin
            mstatus_new[MS_MIE]              = csr_in.mstatus[MS_MPIE];
            mstatus_new[MS_MPIE]             = 1'b1;
            mstatus_new[MS_MPP_HI:MS_MPP_LO] = 2'b00;
            priv_new                         = csr_in.mstatus[MS_MPP_HI:MS_MPP_LO];
        end else if (d_sret) begin
            mstatus_new[MS_SIE]  = csr_in.mstatus[MS_SPIE];
            mstatus_new[MS_SPIE] = 1'b1;
            mstatus_new[MS_SPP]  = 1'b0;
            priv_new             = {1'b0, csr_in.mstatus[MS_SPP]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (any_evt) state_d = ST_FLUSH;
            ST_FLUSH:    if (cnt_q == 4'd0) state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmt_ready   = (state_q == ST_IDLE);
        trap_we     = (state_q == ST_IDLE) && d_trap;
        xret_we     = (state_q == ST_IDLE) && (d_mret || d_sret);
        switch_mode = trap_we || xret_we;
        trap_to_s   = trap_we && d_to_s;
        flush       = (state_q == ST_FLUSH) || (state_q == ST_REDIRECT);
        redirect    = (state_q == ST_REDIRECT);
    end

    // Counter is reloaded every idle cycle so FLUSH always starts full.
    assign cnt_d      = (state_q == ST_IDLE) ? FLUSH_LOAD
                      : (state_q == ST_FLUSH && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    assign priv_d     = evt ? priv_new : priv_q;
    assign redir_pc_d = evt ? d_tgt_pc : redir_pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            priv_q        <= RESET_PRIV;
            redir_pc_q    <= '0;
            cosim_epc_q   <= '0;
            cosim_cause_q <= '0;
            cosim_tval_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            priv_q     <= priv_d;
            redir_pc_q <= redir_pc_d;
            if (trap_we) begin
                cosim_epc_q   <= cmt_pc;
                cosim_cause_q <= d_cause;
                cosim_tval_q  <= d_tval;
            end
        end
    end

    assign trap_epc    = cmt_pc;
    assign trap_cause  = d_cause;
    assign trap_tval   = d_tval;
    assign new_mstatus = mstatus_new;
    assign priv        = priv_q;
    assign cosim_epc   = cosim_epc_q;
    assign cosim_cause = cosim_cause_q;
    assign cosim_tval  = cosim_tval_q;
    assign redirect_pc = redir_pc_q;

endmodule
